// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the three buses around the shared-memory arbiter:
//   - instruction-fetch port : if_req, if_addr -> if_rdata, if_ack, if_stall
//   - load/store port        : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ack, dm_stall
//   - memory bus             : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   - status                 : owner_dm, busy
// Modport "slave" is the arbiter's view; "master" is the core/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_stall;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_stall;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          owner_dm;
  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, owner_dm, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, owner_dm, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the MIPS IF stage
// and MEM stage. Requests are serialised: a grant drives the memory bus for
// LAT cycles, read data is captured at the end of the last access cycle and
// the owner's ack pulses in the following (DONE) cycle. Data accesses win
// ties unless IF has watched STARVE consecutive DM grants.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave (IF port, DM port, memory bus, status)
// Parameters: AW/DW bus widths, LAT access latency (1..15),
//             STARVE anti-starvation limit (1..15).
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD   = 4'(LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic [3:0]    starve_cnt_reg;
  logic          owner_dm_reg;
  logic          cancel_reg;
  logic          if_ack_reg;
  logic          dm_ack_reg;
  logic [DW-1:0] if_rdata_reg;
  logic [DW-1:0] dm_rdata_reg;
  logic          mem_en_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;

  // Arbitration runs in IDLE and DONE. In DONE the port just served may
  // still be holding its (already satisfied) request, so it is masked out.
  logic arb_open;
  logic served_if;
  logic served_dm;
  logic if_cand;
  logic dm_cand;
  logic starved;
  logic grant_if;
  logic grant_dm;

  assign arb_open  = (state_reg != ACCESS);
  assign served_if = (state_reg == DONE) && !owner_dm_reg;
  assign served_dm = (state_reg == DONE) && owner_dm_reg;
  assign if_cand   = arb_open && bus.if_req && !served_if;
  assign dm_cand   = arb_open && bus.dm_req && !served_dm;
  assign starved   = (starve_cnt_reg == STARVE_MAX);
  assign grant_if  = if_cand && (!dm_cand || starved);
  assign grant_dm  = dm_cand && !grant_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      starve_cnt_reg <= '0;
      owner_dm_reg   <= 1'b0;
      cancel_reg     <= 1'b0;
      if_ack_reg     <= 1'b0;
      dm_ack_reg     <= 1'b0;
      if_rdata_reg   <= '0;
      dm_rdata_reg   <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      if_ack_reg <= 1'b0;
      dm_ack_reg <= 1'b0;

      // The starvation count only means something while IF is waiting.
      if (!bus.if_req || grant_if) begin
        starve_cnt_reg <= '0;
      end else if (grant_dm && !starved) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end

      case (state_reg)
        IDLE, DONE: begin
          if (grant_if || grant_dm) begin
            state_reg     <= ACCESS;
            cnt_reg       <= CNT_LOAD;
            owner_dm_reg  <= grant_dm;
            cancel_reg    <= 1'b0;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= grant_dm && bus.dm_we;
            mem_addr_reg  <= grant_dm ? bus.dm_addr : bus.if_addr;
            mem_wdata_reg <= grant_dm ? bus.dm_wdata : '0;
          end else begin
            state_reg <= IDLE;
          end
        end

        ACCESS: begin
          // A fetch whose request drops at any point of the access was
          // flushed by the pipeline; the access still runs to completion.
          if (!owner_dm_reg && !bus.if_req) begin
            cancel_reg <= 1'b1;
          end
          if (cnt_reg == 4'd0) begin
            state_reg     <= DONE;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if (owner_dm_reg) begin
              dm_ack_reg <= 1'b1;
              if (!mem_we_reg) begin
                dm_rdata_reg <= bus.mem_rdata;
              end
            end else begin
              if_rdata_reg <= bus.mem_rdata;
              if_ack_reg   <= !cancel_reg && bus.if_req;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = if_rdata_reg;
  assign bus.if_ack    = if_ack_reg;
  assign bus.if_stall  = bus.if_req && !if_ack_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.dm_ack    = dm_ack_reg;
  assign bus.dm_stall  = bus.dm_req && !dm_ack_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.owner_dm  = owner_dm_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule
